d5m_config_sequencer: RTL and testbench
=======================================

D5M_CONFIG_SEQUENCER -- requirements
Module: d5m_config_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of entries in the sensor register table (1..16).
REQ-002 SHALL have parameter RST_CYCLES, default 16, number of cycles the sensor reset is held low.
REQ-003 SHALL have parameter BOOT_CYCLES, default 64, number of cycles to wait after sensor reset release.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 1024, maximum number of cycles to wait for a write acknowledge.
REQ-005 SHALL have parameter MAX_RETRY, default 2, number of retries allowed per write.
REQ-006 SHALL have port ul1Clock, input, 1 bit: the single clock.
REQ-007 SHALL have port ul1Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port ul1Start, input, 1 bit: one-cycle pulse that starts configuration.
REQ-009 SHALL have port ul1ExpUpdate, input, 1 bit: pulse that requests an exposure write.
REQ-010 SHALL have port ul16Exposure, input, 16 bits: shutter width value, sampled on ul1ExpUpdate.
REQ-011 SHALL have port ul4TblIdx, output, 4 bits: register table index, looked up combinationally by an external ROM.
REQ-012 SHALL have port ul8TblAddr, input, 8 bits: sensor register address returned for ul4TblIdx.
REQ-013 SHALL have port ul16TblData, input, 16 bits: sensor register data returned for ul4TblIdx.
REQ-014 SHALL have port ul1WrReq, output, 1 bit: write request to the serial-bus master.
REQ-015 SHALL have port ul8WrAddr, output, 8 bits: write address.
REQ-016 SHALL have port ul16WrData, output, 16 bits: write data.
REQ-017 SHALL have port ul1WrAck, input, 1 bit: one-cycle pulse signalling the write completed.
REQ-018 SHALL have port ul1WrErr, input, 1 bit: one-cycle pulse signalling the write was NACKed.
REQ-019 SHALL have port ul1SensorResetN, output, 1 bit: sensor reset, active-low.
REQ-020 SHALL have port ul1CaptureEn, output, 1 bit: enables the image-transfer driver.
REQ-021 SHALL have port ul1Busy, output, 1 bit: sequence in progress.
REQ-022 SHALL have port ul1Error, output, 1 bit: sticky fault flag.

Function
REQ-023 SHALL implement the states IDLE, SRST, BOOT, TREQ, TWAIT, RUN, EREQ, EWAIT and FAULT.
REQ-024 SHALL move IDLE->SRST on ul1Start; ul1Start SHALL be ignored in every other state.
REQ-025 SHALL hold ul1SensorResetN low for exactly RST_CYCLES cycles in SRST, then go to BOOT; BOOT SHALL last exactly BOOT_CYCLES cycles, then go to TREQ with index 0.
REQ-026 SHALL, in TREQ, register ul8TblAddr/ul16TblData onto ul8WrAddr/ul16WrData, assert ul1WrReq, and go to TWAIT the next cycle.
REQ-027 SHALL keep ul1WrReq and the address/data stable from assertion until ul1WrAck or ul1WrErr, or until the timeout.
REQ-028 SHALL deassert ul1WrReq, in TWAIT, on the cycle after ul1WrAck, and SHALL then advance the index; after index NUM_REGS-1 it SHALL go to RUN, with no wrap to 0.
REQ-029 SHALL treat ul1WrErr, or ACK_TIMEOUT cycles without an ack, as a failure: the retry counter increments and the same entry is reissued via TREQ.
REQ-030 SHALL go to FAULT and set ul1Error after MAX_RETRY+1 failed attempts on one entry.
REQ-031 SHALL give ul1WrAck priority if ul1WrAck and ul1WrErr occur in the same cycle.
REQ-032 SHALL assert ul1CaptureEn only in RUN, EREQ and EWAIT.
REQ-033 SHALL latch ul16Exposure on an ul1ExpUpdate received in RUN and write address 0x09 via EREQ/EWAIT, using the same ack, retry and timeout rules.
REQ-034 SHALL set a pending flag for an ul1ExpUpdate received in EREQ/EWAIT; the newest value overwrites the latched value, and one further write is issued after the current one completes.
REQ-035 SHALL ignore ul1ExpUpdate outside RUN, EREQ and EWAIT.
REQ-036 SHALL assert ul1Busy in SRST, BOOT, TREQ, TWAIT, EREQ and EWAIT.
REQ-037 SHALL hold ul1SensorResetN low in FAULT; only ul1Reset exits FAULT.
REQ-038 SHALL size all counters for their parameter maxima, with no overflow.

Reset
REQ-039 SHALL, on ul1Reset, immediately force: state IDLE, ul1WrReq 0, ul8WrAddr 0, ul16WrData 0, ul4TblIdx 0, ul1SensorResetN 0, ul1CaptureEn 0, ul1Busy 0, ul1Error 0, all counters 0, pending flag 0.
REQ-040 SHALL, on ul1Reset mid-write, drop ul1WrReq asynchronously and discard the write; a later ack SHALL be ignored.
REQ-041 SHALL release ul1SensorResetN only from SRST completion onward.

Verification
REQ-042 SHALL cover nominal config: NUM_REGS=3, table {(0x01,0x0036),(0x02,0x0010),(0x20,0xC000)}, ack 5 cycles after each req -> three writes issued in order, then RUN with ul1CaptureEn=1 and ul1Busy=0.
REQ-043 SHALL cover NACK retry: ul1WrErr on the first attempt of entry 1 -> the same (0x02,0x0010) is reissued, the second attempt is acked, and the sequence completes.
REQ-044 SHALL cover fault: no ack ever for entry 0 -> after 3x ACK_TIMEOUT cycles the state is FAULT, ul1Error=1, ul1SensorResetN=0, and ul1Start is ignored.
REQ-045 SHALL cover exposure: in RUN, pulse ul1ExpUpdate with 0x0400, then 0x0800 while in EWAIT -> writes (0x09,0x0400) then (0x09,0x0800), with ul1CaptureEn=1 throughout.
REQ-046 SHALL cover reset mid-write: ul1Reset asserted during TWAIT -> all outputs take reset values within the same cycle, and a following ack is ignored.
REQ-047 SHALL cover simultaneous ack+err: both pulsed together -> the write is treated as acked and the index advances.

Source files
------------

// File: rtl/d5m_config_sequencer.sv
// Power-up and register-write sequencer for a D5M image sensor: resets the sensor,
// writes a ROM-held register table over a serial-bus master, then services exposure updates.
module d5m_config_sequencer #(
  parameter int NUM_REGS    = 8,
  parameter int RST_CYCLES  = 16,
  parameter int BOOT_CYCLES = 64,
  parameter int ACK_TIMEOUT = 1024,
  parameter int MAX_RETRY   = 2
) (
  input  logic        ul1Clock,
  input  logic        ul1Reset,
  input  logic        ul1Start,
  input  logic        ul1ExpUpdate,
  input  logic [15:0] ul16Exposure,
  output logic [3:0]  ul4TblIdx,
  input  logic [7:0]  ul8TblAddr,
  input  logic [15:0] ul16TblData,
  output logic        ul1WrReq,
  output logic [7:0]  ul8WrAddr,
  output logic [15:0] ul16WrData,
  input  logic        ul1WrAck,
  input  logic        ul1WrErr,
  output logic        ul1SensorResetN,
  output logic        ul1CaptureEn,
  output logic        ul1Busy,
  output logic        ul1Error
);

  localparam int PHASE_MAX = (RST_CYCLES > BOOT_CYCLES) ? RST_CYCLES : BOOT_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int TMO_W     = $clog2(ACK_TIMEOUT + 1);
  localparam int RETRY_W   = $clog2(MAX_RETRY + 2);
  localparam logic [7:0] EXP_ADDR = 8'h09;

  typedef enum logic [3:0] {
    S_IDLE, S_SRST, S_BOOT, S_TREQ, S_TWAIT, S_RUN, S_EREQ, S_EWAIT, S_FAULT
  } state_t;

  state_t              state;
  logic [PHASE_W-1:0]  phase_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [RETRY_W-1:0]  retry_cnt;
  logic [15:0]         exp_val;
  logic                exp_pending;

  logic attempt_failed;
  logic retries_spent;

  // Ack wins over a simultaneous error; otherwise an error or expired wait fails the attempt.
  assign attempt_failed = !ul1WrAck && (ul1WrErr || (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)));
  assign retries_spent  = (retry_cnt == RETRY_W'(MAX_RETRY));

  // NOTE: sequential state uses non-blocking assignments only, so every register in this
  // block samples the pre-edge values and the order of statements never matters.
  always_ff @(posedge ul1Clock or posedge ul1Reset) begin
    if (ul1Reset) begin
      state           <= S_IDLE;
      phase_cnt       <= '0;
      tmo_cnt         <= '0;
      retry_cnt       <= '0;
      exp_val         <= '0;
      exp_pending     <= 1'b0;
      ul4TblIdx       <= '0;
      ul1WrReq        <= 1'b0;
      ul8WrAddr       <= '0;
      ul16WrData      <= '0;
      ul1SensorResetN <= 1'b0;
      ul1CaptureEn    <= 1'b0;
      ul1Busy         <= 1'b0;
      ul1Error        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (ul1Start) begin
          state     <= S_SRST;
          phase_cnt <= '0;
          ul1Busy   <= 1'b1;
        end

        S_SRST: if (phase_cnt == PHASE_W'(RST_CYCLES - 1)) begin
          state           <= S_BOOT;
          phase_cnt       <= '0;
          ul1SensorResetN <= 1'b1;
        end else begin
          phase_cnt <= phase_cnt + 1'b1;
        end

        S_BOOT: if (phase_cnt == PHASE_W'(BOOT_CYCLES - 1)) begin
          state     <= S_TREQ;
          phase_cnt <= '0;
          ul4TblIdx <= '0;
        end else begin
          phase_cnt <= phase_cnt + 1'b1;
        end

        S_TREQ: begin
          ul8WrAddr  <= ul8TblAddr;
          ul16WrData <= ul16TblData;
          ul1WrReq   <= 1'b1;
          tmo_cnt    <= '0;
          state      <= S_TWAIT;
        end

        S_TWAIT: if (ul1WrAck) begin
          ul1WrReq  <= 1'b0;
          retry_cnt <= '0;
          if (ul4TblIdx == 4'(NUM_REGS - 1)) begin
            state        <= S_RUN;
            ul1Busy      <= 1'b0;
            ul1CaptureEn <= 1'b1;
          end else begin
            ul4TblIdx <= ul4TblIdx + 1'b1;
            state     <= S_TREQ;
          end
        end else if (attempt_failed) begin
          ul1WrReq <= 1'b0;
          if (retries_spent) begin
            state           <= S_FAULT;
            ul1Error        <= 1'b1;
            ul1Busy         <= 1'b0;
            ul1CaptureEn    <= 1'b0;
            ul1SensorResetN <= 1'b0;
          end else begin
            retry_cnt <= retry_cnt + 1'b1;
            state     <= S_TREQ;
          end
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end

        S_RUN: if (ul1ExpUpdate) begin
          exp_val <= ul16Exposure;
          state   <= S_EREQ;
          ul1Busy <= 1'b1;
        end

        S_EREQ: begin
          ul8WrAddr <= EXP_ADDR;
          ul1WrReq  <= 1'b1;
          tmo_cnt   <= '0;
          state     <= S_EWAIT;
          // A retry resends the value already on the bus; only a fresh write consumes exp_val.
          if (retry_cnt == '0) begin
            ul16WrData  <= exp_val;
            exp_pending <= ul1ExpUpdate;
          end else begin
            exp_pending <= exp_pending | ul1ExpUpdate;
          end
          if (ul1ExpUpdate) exp_val <= ul16Exposure;
        end

        S_EWAIT: begin
          if (ul1ExpUpdate) begin
            exp_val     <= ul16Exposure;
            exp_pending <= 1'b1;
          end
          if (ul1WrAck) begin
            ul1WrReq  <= 1'b0;
            retry_cnt <= '0;
            if (exp_pending || ul1ExpUpdate) begin
              state <= S_EREQ;
            end else begin
              state   <= S_RUN;
              ul1Busy <= 1'b0;
            end
          end else if (attempt_failed) begin
            ul1WrReq <= 1'b0;
            if (retries_spent) begin
              state           <= S_FAULT;
              ul1Error        <= 1'b1;
              ul1Busy         <= 1'b0;
              ul1CaptureEn    <= 1'b0;
              ul1SensorResetN <= 1'b0;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_EREQ;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_FAULT: ;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d5m_config_sequencer.sv
// Randomized self-checking bench: a bus-slave process answers each write from a response
// plan, and an attempt-level model derives the write sequence and final status from that plan.
module tb_d5m_config_sequencer;

  localparam int NUM_REGS    = 3;
  localparam int RST_CYCLES  = 4;
  localparam int BOOT_CYCLES = 6;
  localparam int ACK_TIMEOUT = 20;
  localparam int MAX_RETRY   = 2;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  typedef struct {
    int kind;
    int delay;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        exp_update = 1'b0;
  logic [15:0] exposure = '0;
  logic [3:0]  tbl_idx;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack, wr_err;
  logic        slv_ack = 1'b0, slv_err = 1'b0, man_ack = 1'b0;
  logic        sensor_reset_n, capture_en, busy, error;

  logic [7:0]  tbl_a [16];
  logic [15:0] tbl_d [16];
  resp_t       resp_q[$];
  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          slave_en = 1'b1;

  assign wr_ack   = slv_ack | man_ack;
  assign wr_err   = slv_err;
  assign tbl_addr = tbl_a[tbl_idx];
  assign tbl_data = tbl_d[tbl_idx];

  always #5 clk = ~clk;

  d5m_config_sequencer #(
    .NUM_REGS(NUM_REGS), .RST_CYCLES(RST_CYCLES), .BOOT_CYCLES(BOOT_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .ul1Clock(clk), .ul1Reset(rst), .ul1Start(start), .ul1ExpUpdate(exp_update),
    .ul16Exposure(exposure), .ul4TblIdx(tbl_idx), .ul8TblAddr(tbl_addr),
    .ul16TblData(tbl_data), .ul1WrReq(wr_req), .ul8WrAddr(wr_addr),
    .ul16WrData(wr_data), .ul1WrAck(wr_ack), .ul1WrErr(wr_err),
    .ul1SensorResetN(sensor_reset_n), .ul1CaptureEn(capture_en),
    .ul1Busy(busy), .ul1Error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus slave: logs each new request and answers it from the head of resp_q.
  initial begin : slave
    int cnt;
    int kind;
    bit req_prev;
    cnt = 0; kind = K_NONE; req_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      slv_ack = 1'b0;
      slv_err = 1'b0;
      if (rst || !slave_en) begin
        cnt = 0;
        req_prev = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            slv_ack = (kind == K_ACK) || (kind == K_BOTH);
            slv_err = (kind == K_ERR) || (kind == K_BOTH);
          end
        end
        if (wr_req && !req_prev) begin
          obs_q.push_back({wr_addr, wr_data});
          if (resp_q.size() > 0) begin
            resp_t r;
            r = resp_q.pop_front();
            kind = r.kind;
            cnt = (r.kind == K_NONE) ? 0 : r.delay;
          end else begin
            cnt = 0;
          end
        end
        req_prev = wr_req;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    obs_q.delete();
    resp_q.delete();
    exp_q.delete();
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " state_idle_busy"}, busy, 0);
    check({tag, " wr_req"}, wr_req, 0);
    check({tag, " wr_addr"}, wr_addr, 0);
    check({tag, " wr_data"}, wr_data, 0);
    check({tag, " tbl_idx"}, tbl_idx, 0);
    check({tag, " sensor_reset_n"}, sensor_reset_n, 0);
    check({tag, " capture_en"}, capture_en, 0);
    check({tag, " error"}, error, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Attempt-level model: walk the response plan entry by entry.
  task automatic model_config(output bit fault);
    int e, fails;
    e = 0; fails = 0; fault = 1'b0;
    exp_q.delete();
    foreach (resp_q[i]) begin
      if (e >= NUM_REGS || fault) break;
      exp_q.push_back({tbl_a[e], tbl_d[e]});
      if (resp_q[i].kind == K_ACK || resp_q[i].kind == K_BOTH) begin
        e++;
        fails = 0;
      end else begin
        fails++;
        if (fails > MAX_RETRY) fault = 1'b1;
      end
    end
  endtask

  task automatic gen_config_plan();
    int e, fails, r;
    resp_t x;
    e = 0; fails = 0;
    resp_q.delete();
    while (e < NUM_REGS && fails <= MAX_RETRY) begin
      r = $urandom_range(0, 99);
      x.kind  = (r < 55) ? K_ACK : (r < 75) ? K_ERR : (r < 85) ? K_BOTH : K_NONE;
      x.delay = $urandom_range(1, 8);
      resp_q.push_back(x);
      if (x.kind == K_ACK || x.kind == K_BOTH) begin
        e++;
        fails = 0;
      end else begin
        fails++;
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, " write count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s write %0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  // mode 0: wait for configuration to end in RUN or FAULT; mode 1: wait for exposure writes.
  task automatic wait_for(input int mode, input int budget, input string tag);
    int n;
    bit done, cap_drop;
    n = 0; done = 1'b0; cap_drop = 1'b0;
    while (!done && n < budget) begin
      if (mode == 0) done = capture_en || error;
      else           done = !busy && (obs_q.size() >= exp_q.size());
      if (mode == 1 && !capture_en) cap_drop = 1'b1;
      if (!done) begin
        tick(1);
        n++;
      end
    end
    check({tag, " finished within budget"}, done, 1);
    if (mode == 1) check({tag, " capture_en held"}, cap_drop, 0);
  endtask

  task automatic run_config(input string tag, output bit fault);
    int budget;
    model_config(fault);
    budget = 200 + resp_q.size() * (ACK_TIMEOUT + 10);
    obs_q.delete();
    pulse_start();
    wait_for(0, budget, tag);
    tick(2);
    compare_writes(tag);
    check({tag, " error"}, error, fault);
    check({tag, " capture_en"}, capture_en, !fault);
    check({tag, " sensor_reset_n"}, sensor_reset_n, !fault);
    check({tag, " busy"}, busy, 0);
    check({tag, " wr_req"}, wr_req, 0);
    if (!fault) check({tag, " final index"}, tbl_idx, NUM_REGS - 1);
  endtask

  // One exposure write of v1, then k back-to-back updates while it is in flight.
  task automatic run_exposure(input string tag, input logic [15:0] v1, input int k,
                              input logic [15:0] upd [3]);
    int nwr, fails, n;
    resp_t x;
    logic [15:0] val;
    resp_q.delete();
    exp_q.delete();
    obs_q.delete();
    nwr = (k > 0) ? 2 : 1;
    for (int w = 0; w < nwr; w++) begin
      val = (w == 0) ? v1 : upd[k - 1];
      fails = $urandom_range(0, MAX_RETRY);
      for (int f = 0; f <= fails; f++) begin
        x.kind  = (f == fails) ? K_ACK : K_ERR;
        x.delay = $urandom_range(4, 8);
        resp_q.push_back(x);
        exp_q.push_back({8'h09, val});
      end
    end
    exposure = v1;
    exp_update = 1'b1;
    tick(1);
    exp_update = 1'b0;
    n = 0;
    while (obs_q.size() < 1 && n < 10) begin
      tick(1);
      n++;
    end
    check({tag, " first request seen"}, obs_q.size() >= 1, 1);
    if (k > 0) begin
      exp_update = 1'b1;
      for (int j = 0; j < k; j++) begin
        exposure = upd[j];
        tick(1);
      end
      exp_update = 1'b0;
    end
    wait_for(1, 400, tag);
    tick(2);
    compare_writes(tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " capture_en"}, capture_en, 1);
  endtask

  initial begin : main
    bit fault;
    int cnt;
    resp_t x;
    logic [15:0] upd [3];

    for (int i = 0; i < 16; i++) begin
      tbl_a[i] = '0;
      tbl_d[i] = '0;
    end
    tbl_a[0] = 8'h01; tbl_d[0] = 16'h0036;
    tbl_a[1] = 8'h02; tbl_d[1] = 16'h0010;
    tbl_a[2] = 8'h20; tbl_d[2] = 16'hC000;

    tick(1);
    check_reset_outputs("reset");
    do_reset();
    check_reset_outputs("after reset");

    exp_update = 1'b1; exposure = 16'h1234;
    tick(1);
    exp_update = 1'b0;
    tick(4);
    check("idle exp_update ignored wr_req", wr_req, 0);
    check("idle exp_update ignored busy", busy, 0);

    // Nominal table with ack five cycles after each request, plus reset/boot timing.
    x.kind = K_ACK; x.delay = 5;
    repeat (3) resp_q.push_back(x);
    model_config(fault);
    pulse_start();
    cnt = 0;
    while (busy && !sensor_reset_n && cnt < 100) begin
      tick(1);
      cnt++;
    end
    check("sensor reset low cycles", cnt, RST_CYCLES);
    cnt = 0;
    while (!wr_req && cnt < 200) begin
      tick(1);
      cnt++;
    end
    check("boot cycles before first request", cnt, BOOT_CYCLES + 1);
    wait_for(0, 300, "nominal");
    tick(2);
    compare_writes("nominal");
    check("nominal capture_en", capture_en, 1);
    check("nominal busy", busy, 0);
    check("nominal error", error, 0);
    check("nominal final index", tbl_idx, NUM_REGS - 1);

    upd[0] = 16'h0800; upd[1] = 16'h0; upd[2] = 16'h0;
    run_exposure("exposure directed", 16'h0400, 1, upd);

    pulse_start();
    tick(3);
    check("start ignored in RUN", busy, 0);

    // NACK on first attempt of entry 1.
    do_reset();
    x.delay = 3;
    x.kind = K_ACK; resp_q.push_back(x);
    x.kind = K_ERR; resp_q.push_back(x);
    x.kind = K_ACK; resp_q.push_back(x); resp_q.push_back(x);
    run_config("nack retry", fault);

    // Simultaneous ack and error on entry 1.
    do_reset();
    x.kind = K_ACK;  resp_q.push_back(x);
    x.kind = K_BOTH; resp_q.push_back(x);
    x.kind = K_ACK;  resp_q.push_back(x);
    run_config("ack+err", fault);

    // Entry 0 never acknowledged.
    do_reset();
    x.kind = K_NONE;
    repeat (3) resp_q.push_back(x);
    run_config("fault", fault);
    pulse_start();
    exp_update = 1'b1;
    tick(1);
    exp_update = 1'b0;
    tick(20);
    check("fault start ignored busy", busy, 0);
    check("fault start ignored error", error, 1);
    check("fault sensor_reset_n", sensor_reset_n, 0);
    check("fault no new writes", obs_q.size(), 3);

    // Reset during TWAIT, followed by a stray ack.
    do_reset();
    x.kind = K_NONE;
    resp_q.push_back(x);
    pulse_start();
    cnt = 0;
    while (!wr_req && cnt < 100) begin
      tick(1);
      cnt++;
    end
    check("midwrite request raised", wr_req, 1);
    tick(2);
    rst = 1'b1;
    #1;
    check_reset_outputs("midwrite async");
    tick(1);
    rst = 1'b0;
    slave_en = 1'b0;
    tick(1);
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    tick(3);
    check_reset_outputs("after stray ack");
    slave_en = 1'b1;

    for (int it = 0; it < 15; it++) begin
      do_reset();
      for (int i = 0; i < NUM_REGS; i++) begin
        tbl_a[i] = 8'($urandom);
        tbl_d[i] = 16'($urandom);
      end
      gen_config_plan();
      run_config($sformatf("rand%0d cfg", it), fault);
      if (!fault) begin
        for (int j = 0; j < 3; j++) upd[j] = 16'($urandom);
        run_exposure($sformatf("rand%0d exp", it), 16'($urandom), $urandom_range(0, 3), upd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
